// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing
//  Purpose  : VGA raster timing generator. Divides the board clock down to
//             the pixel rate and produces the raster coordinates used by the
//             overlay stages. It also produces sync and visible-area pin
//             signals, delayed to line up with the overlay pipeline.
//
//  Ports    : clock        in   system clock (single domain)
//             reset_n      in   asynchronous active-low reset
//             pix_en       out  one-clock pixel tick, every PIX_DIV clocks
//             hcount[9:0]  out  pixel column, 0..H_TOTAL-1
//             vcount[9:0]  out  line number, 0..V_TOTAL-1
//             line_start   out  one-clock pulse when hcount becomes 0
//             frame_start  out  one-clock pulse when hcount and vcount become 0
//             hsync        out  horizontal sync, delayed PIPE_DELAY clocks
//             vsync        out  vertical sync, delayed PIPE_DELAY clocks
//             video_on     out  visible-area flag, delayed PIPE_DELAY clocks
//
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing #(
    parameter int   H_VISIBLE  = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BACK     = 48,
    parameter int   V_VISIBLE  = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BACK     = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIX_DIV    = 2,
    parameter int   PIPE_DELAY = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int c_DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(PIX_DIV - 1);

    localparam logic [9:0] c_H_LAST = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST = 10'(c_V_TOTAL - 1);

    // Decode bounds are 11 bits wide: a sync region ending at the last
    // column of a 1024-wide line has an exclusive end of 1024.
    localparam logic [10:0] c_H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] c_HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] c_VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    // Delay-line idle word: {hsync, vsync, video_on} all inactive.
    localparam logic [2:0] c_IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (c_H_TOTAL > 1024) begin : g_err_htotal
        $error("vga_timing: H_TOTAL exceeds 1024");
    end
    if (c_V_TOTAL > 1024) begin : g_err_vtotal
        $error("vga_timing: V_TOTAL exceeds 1024");
    end
    if (PIX_DIV < 1 || PIX_DIV > 8) begin : g_err_pixdiv
        $error("vga_timing: PIX_DIV must be 1..8");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_err_delay
        $error("vga_timing: PIPE_DELAY must be 0..4");
    end

    // ------------------------------------------------------------------
    // Pixel-rate divider
    // ------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div;
    logic               r_pix_en;

    // pix_en is registered from the divider so that it is low in reset and
    // first rises on the PIX_DIV-th edge after release (every edge when
    // PIX_DIV is 1).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
            r_pix_en <= (r_div == c_DIV_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Raster counters and start-of-line/frame pulses
    // ------------------------------------------------------------------
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_line_start;
    logic       r_frame_start;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // Pulses are raised on the same edge that loads the wrapped
            // counter values, so they line up with hcount = 0.
            r_line_start  <= r_pix_en && (r_hcount == c_H_LAST);
            r_frame_start <= r_pix_en && (r_hcount == c_H_LAST) &&
                             (r_vcount == c_V_LAST);
            if (r_pix_en) begin
                if (r_hcount == c_H_LAST) begin
                    r_hcount <= '0;
                    r_vcount <= (r_vcount == c_V_LAST) ? '0 : r_vcount + 10'd1;
                end else begin
                    r_hcount <= r_hcount + 10'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Raw sync / visible decode from the registered counters
    // ------------------------------------------------------------------
    logic [10:0] w_hcount_x;
    logic [10:0] w_vcount_x;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic        w_von_raw;

    assign w_hcount_x = {1'b0, r_hcount};
    assign w_vcount_x = {1'b0, r_vcount};

    assign w_hs_raw  = ((w_hcount_x >= c_HS_START) && (w_hcount_x < c_HS_END))
                       ? SYNC_POL : ~SYNC_POL;
    assign w_vs_raw  = ((w_vcount_x >= c_VS_START) && (w_vcount_x < c_VS_END))
                       ? SYNC_POL : ~SYNC_POL;
    assign w_von_raw = (w_hcount_x < c_H_VIS) && (w_vcount_x < c_V_VIS);

    // ------------------------------------------------------------------
    // Output delay line (runs every clock, independent of pix_en)
    // ------------------------------------------------------------------
    if (PIPE_DELAY == 0) begin : g_no_delay
        // Pins follow the counter decode directly; while reset is held the
        // counters sit at (0,0), so video_on reflects that position.
        assign hsync    = w_hs_raw;
        assign vsync    = w_vs_raw;
        assign video_on = w_von_raw;
    end else begin : g_delay
        logic [2:0] r_pipe [PIPE_DELAY];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < PIPE_DELAY; i++) begin
                    r_pipe[i] <= c_IDLE;
                end
            end else begin
                r_pipe[0] <= {w_hs_raw, w_vs_raw, w_von_raw};
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end

        assign {hsync, vsync, video_on} = r_pipe[PIPE_DELAY-1];
    end

    assign pix_en      = r_pix_en;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing
//  Purpose  : Self-checking bench for vga_timing. Three instances (default
//             640x480 timing, a small raster with slow divider and two-stage
//             delay, and a small raster with PIX_DIV=1 / no delay / positive
//             sync) share clock and reset. Expected outputs are computed from
//             the number of clock edges since reset release with plain
//             arithmetic, and compared every clock and right after each
//             asynchronous reset assertion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing;

    // Instance A: small raster, slow divider, two-clock delay, active-low.
    localparam int A_HV = 20, A_HF = 3, A_HS = 5, A_HB = 4;
    localparam int A_VV = 6,  A_VF = 2, A_VS = 2, A_VB = 3;
    localparam int A_PD = 3,  A_DL = 2;
    localparam logic A_POL = 1'b0;

    // Instance B: tiny raster, one clock per pixel, no delay, active-high.
    localparam int B_HV = 12, B_HF = 2, B_HS = 3, B_HB = 3;
    localparam int B_VV = 5,  B_VF = 1, B_VS = 2, B_VB = 2;
    localparam int B_PD = 1,  B_DL = 0;
    localparam logic B_POL = 1'b1;

    // Instance C: default 640x480 timing.
    localparam int C_HV = 640, C_HF = 16, C_HS = 96, C_HB = 48;
    localparam int C_VV = 480, C_VF = 10, C_VS = 2,  C_VB = 33;
    localparam int C_PD = 2,   C_DL = 1;
    localparam logic C_POL = 1'b0;

    typedef struct packed {
        logic       pix;
        logic [9:0] h;
        logic [9:0] v;
        logic       ls;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       von;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   k;
    int   checks = 0;
    int   errors = 0;
    bit   run_chk = 1'b0;

    logic       a_pix, a_ls, a_fs, a_hs, a_vs, a_von;
    logic [9:0] a_h, a_v;
    logic       b_pix, b_ls, b_fs, b_hs, b_vs, b_von;
    logic [9:0] b_h, b_v;
    logic       c_pix, c_ls, c_fs, c_hs, c_vs, c_von;
    logic [9:0] c_h, c_v;

    vga_timing #(
        .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .SYNC_POL(A_POL), .PIX_DIV(A_PD), .PIPE_DELAY(A_DL)
    ) u_dut_a (
        .clock(clock), .reset_n(reset_n), .pix_en(a_pix),
        .hcount(a_h), .vcount(a_v), .line_start(a_ls), .frame_start(a_fs),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_von)
    );

    vga_timing #(
        .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .SYNC_POL(B_POL), .PIX_DIV(B_PD), .PIPE_DELAY(B_DL)
    ) u_dut_b (
        .clock(clock), .reset_n(reset_n), .pix_en(b_pix),
        .hcount(b_h), .vcount(b_v), .line_start(b_ls), .frame_start(b_fs),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_von)
    );

    vga_timing u_dut_c (
        .clock(clock), .reset_n(reset_n), .pix_en(c_pix),
        .hcount(c_h), .vcount(c_v), .line_start(c_ls), .frame_start(c_fs),
        .hsync(c_hs), .vsync(c_vs), .video_on(c_von)
    );

    initial forever #5 clock = ~clock;

    // Edges since reset release; zero while reset is held.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) k <= 0;
        else          k <= k + 1;
    end

    // Reference: after n edges the pixel position is the number of pix_en
    // ticks that have been consumed by the counters, modulo the frame size.
    function automatic int ticks(input int n, input int pd);
        return (n >= 1) ? (n - 1) / pd : 0;
    endfunction

    function automatic exp_t model(input int n,
                                   input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb,
                                   input logic pol, input int pd, input int dl);
        exp_t e;
        int   ht, vt, p, q, hh, ll, nd;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        e  = '0;
        p  = ticks(n, pd) % (ht * vt);
        e.pix = (n >= 1) && (n % pd == 0);
        e.h   = 10'(p % ht);
        e.v   = 10'(p / ht);
        // A counter advance happened on the last edge iff a tick preceded it.
        e.ls  = (n >= 2) && ((n - 1) % pd == 0) && (p % ht == 0);
        e.fs  = (n >= 2) && ((n - 1) % pd == 0) && (p == 0);
        nd = n - dl;
        if (nd < 0) begin
            e.hs  = ~pol;
            e.vs  = ~pol;
            e.von = 1'b0;
        end else begin
            q  = ticks(nd, pd) % (ht * vt);
            hh = q % ht;
            ll = q / ht;
            e.hs  = (hh >= hv + hf && hh < hv + hf + hsw) ? pol : ~pol;
            e.vs  = (ll >= vv + vf && ll < vv + vf + vsw) ? pol : ~pol;
            e.von = (hh < hv) && (ll < vv);
        end
        return e;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at k=%0d t=%0t: got %0d expected %0d", tag, k, $time, got, exp);
        end
    endtask

    task automatic check_all();
        exp_t e;
        e = model(k, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_POL, A_PD, A_DL);
        chk_eq("A.pix_en", 32'(a_pix), 32'(e.pix));
        chk_eq("A.hcount", 32'(a_h),   32'(e.h));
        chk_eq("A.vcount", 32'(a_v),   32'(e.v));
        chk_eq("A.line_start",  32'(a_ls), 32'(e.ls));
        chk_eq("A.frame_start", 32'(a_fs), 32'(e.fs));
        chk_eq("A.hsync",    32'(a_hs),  32'(e.hs));
        chk_eq("A.vsync",    32'(a_vs),  32'(e.vs));
        chk_eq("A.video_on", 32'(a_von), 32'(e.von));
        e = model(k, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_POL, B_PD, B_DL);
        chk_eq("B.pix_en", 32'(b_pix), 32'(e.pix));
        chk_eq("B.hcount", 32'(b_h),   32'(e.h));
        chk_eq("B.vcount", 32'(b_v),   32'(e.v));
        chk_eq("B.line_start",  32'(b_ls), 32'(e.ls));
        chk_eq("B.frame_start", 32'(b_fs), 32'(e.fs));
        chk_eq("B.hsync",    32'(b_hs),  32'(e.hs));
        chk_eq("B.vsync",    32'(b_vs),  32'(e.vs));
        chk_eq("B.video_on", 32'(b_von), 32'(e.von));
        e = model(k, C_HV, C_HF, C_HS, C_HB, C_VV, C_VF, C_VS, C_VB, C_POL, C_PD, C_DL);
        chk_eq("C.pix_en", 32'(c_pix), 32'(e.pix));
        chk_eq("C.hcount", 32'(c_h),   32'(e.h));
        chk_eq("C.vcount", 32'(c_v),   32'(e.v));
        chk_eq("C.line_start",  32'(c_ls), 32'(e.ls));
        chk_eq("C.frame_start", 32'(c_fs), 32'(e.fs));
        chk_eq("C.hsync",    32'(c_hs),  32'(e.hs));
        chk_eq("C.vsync",    32'(c_vs),  32'(e.vs));
        chk_eq("C.video_on", 32'(c_von), 32'(e.von));
    endtask

    // Sample on the falling edge, half a period away from the active edge.
    always @(negedge clock) begin
        if (run_chk) check_all();
    end

    initial begin
        int n;
        run_chk = 1'b1;
        // Initial reset held for five clocks.
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b1;

        for (int seg = 0; seg < 10; seg++) begin
            // First run is long enough for several small frames and
            // two full default lines; later runs are random lengths.
            n = (seg == 0) ? 4000 : int'($urandom_range(100, 3500));
            repeat (n) @(negedge clock);
            // Assert reset between edges; outputs must already be at their
            // reset values before the next rising edge.
            #2 reset_n = 1'b0;
            #1 check_all();
            repeat ($urandom_range(1, 4)) @(negedge clock);
            #2 reset_n = 1'b1;
        end

        repeat (50) @(negedge clock);
        run_chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
